// File: rtl/cnn_mac_pkg.sv
// Shared widths, sideband payload and fixed-point helpers for the CNN MAC datapath.
package cnn_mac_pkg;

  localparam int unsigned DIN0_WIDTH_DEF = 8;
  localparam int unsigned DIN1_WIDTH_DEF = 12;
  localparam int unsigned ACC_WIDTH_DEF  = 32;
  localparam int unsigned FRAC_SHIFT_DEF = 6;
  localparam int unsigned OUT_WIDTH_DEF  = 12;
  localparam int unsigned NUM_STAGE_DEF  = 2;

  // Working width for round/saturate; accumulators up to this width are supported.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_side_t;

  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1;
  endfunction

  // Round half up toward +inf, then arithmetic shift right.
  function automatic logic signed [MAX_W-1:0] round_shift(input logic signed [MAX_W-1:0] v,
                                                          input int unsigned shift);
    logic signed [MAX_W-1:0] bias;
    if (shift == 0) return v;
    bias = $signed(MAX_W'(1) << (shift - 1));
    return (v + bias) >>> shift;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_clip(input logic signed [MAX_W-1:0] v,
                                                       input int unsigned w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [MAX_W-1:0] v, input int unsigned w);
    return (v != sat_clip(v, w));
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Pipelined signed multiplier: registered operands, then NUM_STAGE product registers,
// with valid/first/last sidebands travelling alongside.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DIN0_WIDTH_DEF,
  parameter int unsigned DIN1_WIDTH = DIN1_WIDTH_DEF,
  parameter int unsigned NUM_STAGE  = NUM_STAGE_DEF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ce,
  input  logic                                      in_valid,
  input  logic                                      in_first,
  input  logic                                      in_last,
  input  logic signed [DIN0_WIDTH-1:0]              din0,
  input  logic signed [DIN1_WIDTH-1:0]              din1,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0]   prod,
  output mac_side_t                                 side
);

  localparam int unsigned P = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [DIN0_WIDTH-1:0] a_q, a_d;
  logic signed [DIN1_WIDTH-1:0] b_q, b_d;
  mac_side_t                    s0_q, s0_d;
  logic signed [P-1:0]          prod_q [NUM_STAGE];
  logic signed [P-1:0]          prod_d [NUM_STAGE];
  mac_side_t                    side_q [NUM_STAGE];
  mac_side_t                    side_d [NUM_STAGE];

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    s0_d = s0_q;
    for (int unsigned i = 0; i < NUM_STAGE; i++) begin
      prod_d[i] = prod_q[i];
      side_d[i] = side_q[i];
    end
    if (ce) begin
      a_d        = din0;
      b_d        = din1;
      s0_d.valid = in_valid;
      s0_d.first = in_valid & in_first;
      s0_d.last  = in_valid & in_last;
      prod_d[0]  = P'(a_q) * P'(b_q);
      side_d[0]  = s0_q;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        prod_d[i] = prod_q[i-1];
        side_d[i] = side_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      s0_q <= '0;
      for (int unsigned i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      s0_q <= s0_d;
      for (int unsigned i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_d[i];
        side_q[i] <= side_d[i];
      end
    end
  end

  assign prod = prod_q[NUM_STAGE-1];
  assign side = side_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC with first/last framing and rounded fixed-point output.
// Define CNN_MAC_SAT_EN to saturate the output; otherwise it wraps and sat stays 0.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DIN0_WIDTH_DEF,
  parameter int unsigned DIN1_WIDTH = DIN1_WIDTH_DEF,
  parameter int unsigned NUM_STAGE  = NUM_STAGE_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  dout,
  output logic signed [ACC_WIDTH-1:0]  dout_acc,
  output logic                         sat
);

  localparam int unsigned P = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [P-1:0] m_prod;
  mac_side_t           m_side;

  cnn_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .din0     (din0),
    .din1     (din1),
    .prod     (m_prod),
    .side     (m_side)
  );

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] acc_base, acc_sum;
  logic signed [ACC_WIDTH-1:0] dout_acc_q, dout_acc_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic signed [MAX_W-1:0]     rnd;
  logic                        out_valid_q, out_valid_d;
  logic                        sat_q, sat_d;

  // Accumulate and round/saturate share one cycle so the result lands with the last term.
  always_comb begin
    acc_d       = acc_q;
    dout_acc_d  = dout_acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    acc_base    = m_side.first ? '0 : acc_q;
    acc_sum     = acc_base + ACC_WIDTH'(m_prod);
    rnd         = round_shift(MAX_W'(acc_sum), FRAC_SHIFT);
    if (ce) begin
      out_valid_d = 1'b0;
      if (m_side.valid) begin
        acc_d = acc_sum;
        if (m_side.last) begin
          out_valid_d = 1'b1;
          dout_acc_d  = acc_sum;
`ifdef CNN_MAC_SAT_EN
          dout_d      = OUT_WIDTH'(sat_clip(rnd, OUT_WIDTH));
          sat_d       = sat_hit(rnd, OUT_WIDTH);
`else
          dout_d      = OUT_WIDTH'(rnd);
          sat_d       = 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      dout_acc_q  <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      dout_acc_q  <= dout_acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_acc  = dout_acc_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed self-checking bench for cnn_mac_pipe at default parameters.
module tb_cnn_mac_pipe;

  logic                clk = 1'b0;
  logic                reset;
  logic                ce;
  logic                in_valid;
  logic                in_first;
  logic                in_last;
  logic signed [7:0]   din0;
  logic signed [11:0]  din1;
  logic                out_valid;
  logic signed [11:0]  dout;
  logic signed [31:0]  dout_acc;
  logic                sat;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  cnn_mac_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .dout      (dout),
    .dout_acc  (dout_acc),
    .sat       (sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din0     = '0;
    din1     = '0;
  endtask

  task automatic term(input logic signed [7:0] a, input logic signed [11:0] b,
                      input logic f, input logic l);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    in_first = f;
    in_last  = l;
    step();
    idle();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    idle();
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (dout !== 12'sd0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", dout); end
    n_cmp++; if (dout_acc !== 32'sd0) begin n_err++; $display("FAIL reset_dout_acc: got %0d want 0", dout_acc); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", sat); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    term(8'sd3, 12'sd64, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", n); end
    n_cmp++; if (dout !== 12'sd3) begin n_err++; $display("FAIL single_dout: got %0d want 3", dout); end
    n_cmp++; if (dout_acc !== 32'sd192) begin n_err++; $display("FAIL single_dout_acc: got %0d want 192", dout_acc); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL single_sat: got %b want 0", sat); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_width: got %b want 0", out_valid); end
  endtask

  task automatic test_sequence();
    int n;
    term(8'sd10, 12'sd100, 1'b1, 1'b0);
    term(-8'sd5, 12'sd40, 1'b0, 1'b0);
    term(8'sd2, -12'sd7, 1'b0, 1'b1);
    wait_out(n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL seq_latency: got %0d want 3", n); end
    n_cmp++; if (dout_acc !== 32'sd786) begin n_err++; $display("FAIL seq_dout_acc: got %0d want 786", dout_acc); end
    n_cmp++; if (dout !== 12'sd12) begin n_err++; $display("FAIL seq_dout: got %0d want 12", dout); end
    step();
  endtask

  task automatic test_rounding();
    int n;
    term(8'sd1, 12'sd32, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== 12'sd1) begin n_err++; $display("FAIL round_pos_dout: got %0d want 1", dout); end
    step();
    term(-8'sd1, 12'sd32, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== 12'sd0) begin n_err++; $display("FAIL round_neg_dout: got %0d want 0", dout); end
    n_cmp++; if (dout_acc !== -32'sd32) begin n_err++; $display("FAIL round_neg_acc: got %0d want -32", dout_acc); end
    step();
  endtask

  task automatic test_saturation();
    int n;
    logic signed [11:0] exp_hi, exp_lo;
    logic               exp_sat;
`ifdef CNN_MAC_SAT_EN
    exp_hi  = 12'sd2047;
    exp_lo  = -12'sd2048;
    exp_sat = 1'b1;
`else
    exp_hi  = -12'sd34;
    exp_lo  = 12'sd2;
    exp_sat = 1'b0;
`endif
    term(8'sd127, 12'sd2047, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (dout_acc !== 32'sd259969) begin n_err++; $display("FAIL sat_hi_acc: got %0d want 259969", dout_acc); end
    n_cmp++; if (dout !== exp_hi) begin n_err++; $display("FAIL sat_hi_dout: got %0d want %0d", dout, exp_hi); end
    n_cmp++; if (sat !== exp_sat) begin n_err++; $display("FAIL sat_hi_flag: got %b want %b", sat, exp_sat); end
    step();
    term(-8'sd128, 12'sd2047, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== exp_lo) begin n_err++; $display("FAIL sat_lo_dout: got %0d want %0d", dout, exp_lo); end
    n_cmp++; if (sat !== exp_sat) begin n_err++; $display("FAIL sat_lo_flag: got %b want %b", sat, exp_sat); end
    step();
  endtask

  task automatic test_ce_stall();
    int n;
    int start;
    term(8'sd10, 12'sd100, 1'b1, 1'b0);
    start    = cyc;
    ce       = 1'b0;
    in_valid = 1'b1;
    din0     = -8'sd5;
    din1     = 12'sd40;
    repeat (3) step();
    ce = 1'b1;
    step();
    idle();
    term(8'sd2, -12'sd7, 1'b0, 1'b1);
    wait_out(n);
    n_cmp++; if (cyc - start !== 8) begin n_err++; $display("FAIL stall_latency: got %0d want 8", cyc - start); end
    n_cmp++; if (dout !== 12'sd12) begin n_err++; $display("FAIL stall_dout: got %0d want 12", dout); end
    ce = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid: got %b want 1", out_valid); end
    n_cmp++; if (dout !== 12'sd12) begin n_err++; $display("FAIL stall_hold_dout: got %0d want 12", dout); end
    ce = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int   n;
    logic seen;
    term(8'sd10, 12'sd100, 1'b1, 1'b0);
    term(-8'sd5, 12'sd40, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      step();
      seen = seen | out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_valid: got %b want 0", seen); end
    n_cmp++; if (dout !== 12'sd0) begin n_err++; $display("FAIL abort_dout_clear: got %0d want 0", dout); end
    term(8'sd2, -12'sd7, 1'b0, 1'b1);
    wait_out(n);
    n_cmp++; if (dout_acc !== -32'sd14) begin n_err++; $display("FAIL nofirst_acc: got %0d want -14", dout_acc); end
    step();
    term(8'sd10, 12'sd100, 1'b1, 1'b0);
    term(-8'sd5, 12'sd40, 1'b0, 1'b0);
    term(8'sd2, -12'sd7, 1'b0, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== 12'sd12) begin n_err++; $display("FAIL fresh_dout: got %0d want 12", dout); end
    n_cmp++; if (dout_acc !== 32'sd786) begin n_err++; $display("FAIL fresh_acc: got %0d want 786", dout_acc); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    term(8'sd3, 12'sd64, 1'b1, 1'b1);
    term(8'sd10, 12'sd100, 1'b1, 1'b0);
    term(-8'sd5, 12'sd40, 1'b0, 1'b0);
    term(8'sd2, -12'sd7, 1'b0, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== 12'sd3) begin n_err++; $display("FAIL b2b_first_dout: got %0d want 3", dout); end
    step();
    wait_out(n);
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", n); end
    n_cmp++; if (dout !== 12'sd12) begin n_err++; $display("FAIL b2b_second_dout: got %0d want 12", dout); end
    n_cmp++; if (dout_acc !== 32'sd786) begin n_err++; $display("FAIL b2b_second_acc: got %0d want 786", dout_acc); end
    step();
    term(8'sd1, 12'sd32, 1'b1, 1'b1);
    term(8'sd3, 12'sd64, 1'b1, 1'b1);
    wait_out(n);
    n_cmp++; if (dout !== 12'sd1) begin n_err++; $display("FAIL b2b_single_a: got %0d want 1", dout); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_consecutive: got %b want 1", out_valid); end
    n_cmp++; if (dout !== 12'sd3) begin n_err++; $display("FAIL b2b_single_b: got %0d want 3", dout); end
    n_cmp++; if (dout_acc !== 32'sd192) begin n_err++; $display("FAIL b2b_single_b_acc: got %0d want 192", dout_acc); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_rounding();
    test_saturation();
    test_ce_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
